// File: rtl/tone_detector.sv
// Tone period tracker: measures rising-edge intervals of a square wave, and when two
// consecutive periods agree, serially divides to recover a phase increment and key code.
module tone_detector #(
  parameter int unsigned C_TOL        = 512,
  parameter int unsigned C_MIN_PERIOD = 1024,
  parameter int unsigned C_CNT_MAX    = 262143,
  parameter int unsigned C_DIV_SHIFT  = 24
) (
  input  logic        CK_i,
  input  logic        ARST_i,
  input  logic        SOUND_i,
  output logic [17:0] PERIOD_o,
  output logic [8:0]  DIV_o,
  output logic [7:0]  KEY_o,
  output logic        VALID_o,
  output logic        DONE_o
);

  localparam logic [17:0] Tol       = 18'(C_TOL);
  localparam logic [17:0] MinPeriod = 18'(C_MIN_PERIOD);
  localparam logic [17:0] CntMax    = 18'(C_CNT_MAX);
  localparam logic [24:0] DivOne    = 25'(2 ** C_DIV_SHIFT);

  typedef enum logic [1:0] {StIdle, StArm, StMeas, StDivide} state_e;

  state_e      state_q;
  logic        sync1_q, sync2_q, sync3_q, edge_q;
  logic [17:0] cnt_q, cnt_d;
  logic [17:0] p0_q;
  logic [17:0] period_q;
  logic [8:0]  div_q;
  logic [7:0]  key_q;
  logic        valid_q, done_q;
  logic [24:0] num_q;
  logic [17:0] rem_q;
  logic [4:0]  step_q;

  logic        accept, timeout, consistent;
  logic [17:0] diff;
  logic [24:0] dividend;
  logic [18:0] trial;
  logic        trial_ge;
  logic [17:0] rem_nx;
  logic [24:0] quot_nx;
  logic [8:0]  div_nx;
  logic [7:0]  key_nx;

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= SOUND_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  // Edges closer than MinPeriod to the last accepted one are glitches and leave no trace.
  always_comb begin
    accept     = edge_q && (cnt_q >= MinPeriod);
    timeout    = (cnt_q == CntMax) && !accept;
    diff       = (cnt_q >= p0_q) ? (cnt_q - p0_q) : (p0_q - cnt_q);
    consistent = (diff <= Tol);
    dividend   = DivOne + {8'd0, cnt_q[17:1]};
    cnt_d      = cnt_q;
    if (accept) begin
      cnt_d = 18'd1;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 18'd1;
    end
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      cnt_q <= 18'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    trial    = {rem_q, num_q[24]};
    trial_ge = (trial >= {1'b0, period_q});
    rem_nx   = trial_ge ? 18'(trial - {1'b0, period_q}) : trial[17:0];
    quot_nx  = {num_q[23:0], trial_ge};
    div_nx   = (|quot_nx[24:9]) ? 9'd511 : quot_nx[8:0];
    if (quot_nx < 25'd85) begin
      key_nx = 8'd0;
    end else if (quot_nx > 25'd340) begin
      key_nx = 8'd255;
    end else begin
      key_nx = 8'(quot_nx - 25'd85);
    end
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      state_q  <= StIdle;
      p0_q     <= 18'd0;
      period_q <= 18'd0;
      div_q    <= 9'd0;
      key_q    <= 8'd0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      num_q    <= 25'd0;
      rem_q    <= 18'd0;
      step_q   <= 5'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StArm;
          end else if (timeout) begin
            valid_q <= 1'b0;
            key_q   <= 8'd0;
          end
        end
        StArm: begin
          if (accept) begin
            p0_q    <= cnt_q;
            state_q <= StMeas;
          end else if (timeout) begin
            valid_q <= 1'b0;
            key_q   <= 8'd0;
            state_q <= StIdle;
          end
        end
        StMeas: begin
          if (accept) begin
            p0_q <= cnt_q;
            if (consistent) begin
              period_q <= cnt_q;
              num_q    <= dividend;
              rem_q    <= 18'd0;
              step_q   <= 5'd0;
              state_q  <= StDivide;
            end
          end else if (timeout) begin
            valid_q <= 1'b0;
            key_q   <= 8'd0;
            state_q <= StIdle;
          end
        end
        StDivide: begin
          if (accept) begin
            p0_q <= cnt_q;
          end
          num_q  <= quot_nx;
          rem_q  <= rem_nx;
          step_q <= step_q + 5'd1;
          if (step_q == 5'd24) begin
            div_q   <= div_nx;
            key_q   <= key_nx;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StMeas;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign PERIOD_o = period_q;
  assign DIV_o    = div_q;
  assign KEY_o    = key_q;
  assign VALID_o  = valid_q;
  assign DONE_o   = done_q;

endmodule

// File: doc/tone_detector.md
TONE_DETECTOR -- requirements
Module: TONE_DETECTOR

Interface
REQ-001 SHALL have parameter C_TOL, default 512: maximum difference, in CK_i cycles, between two consecutive periods for them to count as consistent.
REQ-002 SHALL have parameter C_MIN_PERIOD, default 1024: any rising-edge interval shorter than this many cycles is a glitch.
REQ-003 SHALL have port CK_i, input, 1 bit: the single clock.
REQ-004 SHALL have port ARST_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port SOUND_i, input, 1 bit: square-wave tone, asynchronous to CK_i.
REQ-006 SHALL have port PERIOD_o, output, 18 bits: last accepted period in CK_i cycles.
REQ-007 SHALL have port DIV_o, output, 9 bits: recovered phase increment, saturated at 511.
REQ-008 SHALL have port KEY_o, output, 8 bits: recovered key code.
REQ-009 SHALL have port VALID_o, output, 1 bit: KEY_o/DIV_o hold a current result.
REQ-010 SHALL have port DONE_o, output, 1 bit: one-cycle pulse when the outputs update.

Function
REQ-011 SHALL pass SOUND_i through a 2-FF synchronizer, then a rising-edge detector; edge pulse E is registered.
REQ-012 SHALL run an 18-bit period counter that increments every cycle, saturates at 262143 and restarts at 1 on an accepted edge.
REQ-013 SHALL ignore an edge when counter < C_MIN_PERIOD: counter not restarted, no state change.
REQ-014 SHALL use FSM states IDLE, ARM, MEAS, DIVIDE.
- IDLE: first accepted edge -> ARM; counter restarts.
- ARM: next accepted edge -> store period P0 -> MEAS.
- MEAS: accepted edge with period P. If |P-P0| <= C_TOL: PERIOD_o<=P, start divide, -> DIVIDE. Otherwise P0<=P and stay in MEAS. In both cases P0<=P.
REQ-015 In DIVIDE, SHALL compute Q = floor((2^24 + floor(P/2)) / P) with a restoring serial divider, one quotient bit per cycle over 25 cycles.
REQ-016 With E accepted at cycle t, SHALL update DIV_o, KEY_o and VALID_o=1 and pulse DONE_o at cycle t+26, then return to MEAS.
REQ-017 SHALL set DIV_o = min(Q,511) and KEY_o = 0 if Q<85, 255 if Q>340, else Q-85.
REQ-018 Edges during DIVIDE SHALL restart the counter and update P0 but SHALL NOT start a new divide or abort the current one.
REQ-019 On counter saturation (262143) in any state except DIVIDE, SHALL clear VALID_o and KEY_o to 0 and go to IDLE; DIV_o and PERIOD_o hold.
REQ-020 When SOUND_i is held constant, no result SHALL be produced; VALID_o drops via timeout.
REQ-021 DONE_o SHALL be high for exactly one cycle per completed divide.

Reset
REQ-022 While ARST_i=1, SHALL force FSM=IDLE, synchronizer and counter=0, P0=0, PERIOD_o=0, DIV_o=0, KEY_o=0, VALID_o=0, DONE_o=0, immediately and without a clock.
REQ-023 Reset asserted mid-DIVIDE SHALL discard the division, with no DONE_o after release.
REQ-024 After ARST_i falls, the first result SHALL need at least three accepted edges.

Verification
REQ-025 Square wave, period 65536 cycles -> third edge +26 cycles: DONE_o=1, PERIOD_o=65536, DIV_o=256, KEY_o=171, VALID_o=1.
REQ-026 Period 197379 -> DIV_o=85, KEY_o=0. Period 49345 -> DIV_o=340, KEY_o=255. Period 40000 -> DIV_o=419, KEY_o=255 (clamped).
REQ-027 Periods alternating 65536/66048 -> result every edge. Alternating 65536/70000 -> no DONE_o.
REQ-028 1-cycle glitch pulse 500 cycles after an edge -> ignored; result identical to the clean wave.
REQ-029 Input stops after a valid result -> VALID_o=0, KEY_o=0 exactly 262143 cycles after the last edge; FSM in IDLE.
REQ-030 ARST_i pulse at cycle t+10 of DIVIDE -> all outputs 0, no DONE_o; next result after three edges.
